soma_sched: RTL
===============

// Module: soma_sched
// PURPOSE
//  Per-timestep sequencer for the soma datapath. On each tick it sweeps neuron
//  addresses 0..neuron_last and issues one config_soma_vld per neuron. It also
//  runs full clear sweeps. It arbitrates the single Vm write port between the
//  sweep write-back slot and axon writes. Fired neuron indices are captured into
//  a spike FIFO, which the spike-out / router stage drains.
// PARAMETERS
//  NNW      12  neuron address width
//  SFAW      3  spike FIFO address width (depth 2**SFAW)
//  PCW      16  perf counter width (SOMA_SCHED_PERF_EN only)
// PORTS
//  clk_soma           in   1    clock
//  rst_n              in   1    synchronous, active-low reset
//  sched_enable       in   1    ticks are ignored while low
//  sched_tick         in   1    pulse: start update sweep
//  sched_clear_req    in   1    pulse: start clear sweep
//  neuron_last        in   NNW  last neuron index (N-1); sampled at sweep start
//  sched_busy         out  1    sweep or drain in progress
//  sched_done         out  1    1-cycle pulse: sweep fully written back
//  sched_overrun      out  1    1-cycle pulse: tick dropped (a tick already pending)
//  config_soma_vld    out  1    soma update strobe
//  config_soma_vm_addr out NNW  soma neuron address
//  config_soma_clear  out  1    qualifies vld as clear (write 0, no read)
//  soma_spk_out_fire  in   1    soma fire; valid the cycle after vld
//  axon_req           in   1    axon wants the Vm write port
//  axon_gnt           out  1    axon write may be applied this cycle
//  spk_valid          out  1    spike FIFO head valid
//  spk_ready          in   1    consumer accepts head
//  spk_addr           out  NNW  fired neuron index
//  perf_stall_cnt     out  PCW  cycles a sweep was stalled (macro only)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, FIFO empty, pending tick cleared, counters 0.
//   Reset mid-sweep aborts; no done pulse.
//  FSM states: IDLE, UPDATE, CLEAR, DRAIN.
//   IDLE->CLEAR on clear_req. Else IDLE->UPDATE on tick&enable, or on a pending tick.
//   Simultaneous clear_req and tick: clear first; the tick is held pending (1 deep).
//   A second tick while a tick is already pending: drop it, pulse sched_overrun.
//   A tick while busy with no tick pending: becomes pending (no overrun).
//   UPDATE/CLEAR->DRAIN after addr==neuron_last is issued.
//   DRAIN->IDLE 1 cycle later (write-back/fire slot). sched_done pulses on that
//   transition. clear_req while busy is ignored.
//  Issue rule: issue=sweep_active & !axon_gnt & !(axon_req & vld_q) & room.
//   vld_q is config_soma_vld delayed 1 cycle.
//   For UPDATE, room = fifo_count+vld_q < 2**SFAW. For CLEAR, room = 1.
//  Arbitration: axon_gnt = axon_req & !vld_q & !(sweep_active & gnt_q).
//   The write slot at vld_q is never granted to axon.
//   Under continuous axon_req plus a sweep, the pattern is gnt, vld, idle,
//   repeating every 3 cycles; neither side starves.
//  Address: counter starts at 0, +1 per issue, and never wraps past neuron_last.
//   neuron_last=0 gives a single issue.
//  Fire capture: when vld_q & !clear_q & soma_spk_out_fire, push addr_q.
//   Overflow is impossible by the room rule; assert this in sim.
//   Fire during CLEAR is ignored.
//  FIFO: show-ahead; pop on spk_valid&spk_ready. Push and pop in the same cycle
//   when full is legal. When empty, spk_addr holds its last value.
//  Stall: a cycle with sweep_active and no issue.
// CONFIGURATION
//  SOMA_SCHED_PERF_EN defined: perf_stall_cnt counts stall cycles. It saturates
//   at 2**PCW-1 and clears at each sweep start and on reset.
//  SOMA_SCHED_PERF_EN undefined: port present, tied to 0, no counter logic.
// STRUCTURE
//  soma_sched_pkg: FSM state enum (2b), localparams ST_IDLE/UPDATE/CLEAR/DRAIN.
//  Sub-module spk_fifo (sync FIFO, width NNW, depth 2**SFAW, count output).
// TESTING
//  1. neuron_last=7, tick, no axon_req, spk_ready=1, fire at addr 2,5
//     -> vld on addr 0..7 consecutively; spk_addr 2 then 5; done 9 cycles after tick.
//  2. clear_req and tick in same cycle, neuron_last=3
//     -> 4 clear issues, done; then 4 update issues, done; no overrun.
//  3. axon_req held high during a sweep of neuron_last=5
//     -> gnt,vld,idle period-3 pattern; gnt never in a vld_q cycle; done once.
//  4. SFAW=3, spk_ready=0, every neuron fires, neuron_last=15
//     -> exactly 8 issues then stall; releasing spk_ready resumes; 16 spikes in order.
//  5. tick while busy with a tick pending -> sched_overrun 1 cycle.
//     Reset asserted mid-sweep -> all outputs 0 next cycle, FIFO empty.
//  6. PERF_EN build, scenario 4 with 10 stalled cycles -> perf_stall_cnt=10.

Source files
------------

// File: rtl/soma_sched_pkg.sv
// Shared types and FSM encodings for the soma timestep sequencer.
package soma_sched_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_UPDATE = 2'd1;
  localparam logic [1:0] ST_CLEAR  = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

endpackage

// File: rtl/soma_sched_spk_fifo.sv
// Show-ahead sync FIFO holding fired neuron indices; the head output holds the
// last popped value while empty.
module spk_fifo #(
  parameter int W  = 12,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic          o_valid,
  output logic [W-1:0]  o_dout,
  output logic [AW:0]   o_count
);

  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  r_mem [1<<AW];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic [W-1:0]  r_hold;
  logic          w_pop, w_push;

  assign w_pop  = i_pop & (r_cnt != '0);
  // A push while full is accepted only when the head leaves in the same cycle.
  assign w_push = i_push & ((r_cnt != FULL) | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_hold <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) begin
        r_rd   <= r_rd + 1'b1;
        r_hold <= r_mem[r_rd];
      end
      r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(i_push && (r_cnt == FULL) && !w_pop));
  end

  assign o_valid = (r_cnt != '0);
  assign o_dout  = o_valid ? r_mem[r_rd] : r_hold;
  assign o_count = r_cnt;

endmodule

// File: rtl/soma_sched.sv
// Per-timestep soma sweep sequencer with Vm write-port arbitration and spike FIFO.
// SOMA_SCHED_PERF_EN enables the saturating sweep stall counter.
module soma_sched
  import soma_sched_pkg::*;
#(
  parameter int NNW  = 12,
  parameter int SFAW = 3,
  parameter int PCW  = 16
) (
  input  logic           clk_soma,
  input  logic           rst_n,
  input  logic           sched_enable,
  input  logic           sched_tick,
  input  logic           sched_clear_req,
  input  logic [NNW-1:0] neuron_last,
  output logic           sched_busy,
  output logic           sched_done,
  output logic           sched_overrun,
  output logic           config_soma_vld,
  output logic [NNW-1:0] config_soma_vm_addr,
  output logic           config_soma_clear,
  input  logic           soma_spk_out_fire,
  input  logic           axon_req,
  output logic           axon_gnt,
  output logic           spk_valid,
  input  logic           spk_ready,
  output logic [NNW-1:0] spk_addr,
  output logic [PCW-1:0] perf_stall_cnt
);

  localparam logic [SFAW+1:0] DEPTH = {2'b01, {SFAW{1'b0}}};

  state_t         r_state;
  logic           r_pend, r_vld_q, r_clr_q, r_gnt_q, r_ovr;
  logic [NNW-1:0] r_addr, r_last, r_addr_q;

  logic           w_tick, w_active, w_start_upd, w_start_clr;
  logic           w_gnt, w_room, w_issue, w_push;
  logic [SFAW:0]  w_fcnt;
  logic [SFAW+1:0] w_occ;

  assign w_tick      = sched_tick & sched_enable;
  assign w_active    = (r_state == ST_UPDATE) | (r_state == ST_CLEAR);
  assign w_start_clr = (r_state == ST_IDLE) & sched_clear_req;
  assign w_start_upd = (r_state == ST_IDLE) & !sched_clear_req & (w_tick | r_pend);

  // The write-back slot (vld_q) belongs to the sweep; after a grant the sweep gets a turn.
  assign w_gnt   = axon_req & !r_vld_q & !(w_active & r_gnt_q);
  // Count the in-flight issue so a fire can never find the FIFO full.
  assign w_occ   = {1'b0, w_fcnt} + {{(SFAW+1){1'b0}}, r_vld_q};
  assign w_room  = (r_state == ST_CLEAR) | (w_occ < DEPTH);
  assign w_issue = w_active & !w_gnt & !(axon_req & r_vld_q) & w_room;
  assign w_push  = r_vld_q & !r_clr_q & soma_spk_out_fire;

  always_ff @(posedge clk_soma) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_pend   <= 1'b0;
      r_vld_q  <= 1'b0;
      r_clr_q  <= 1'b0;
      r_gnt_q  <= 1'b0;
      r_ovr    <= 1'b0;
      r_addr   <= '0;
      r_last   <= '0;
      r_addr_q <= '0;
    end else begin
      r_vld_q  <= w_issue;
      r_clr_q  <= w_issue & (r_state == ST_CLEAR);
      r_gnt_q  <= w_gnt;
      r_addr_q <= r_addr;
      r_ovr    <= w_tick & r_pend & !w_start_upd;
      // Starting from a pending tick frees the slot for a same-cycle tick.
      if (w_start_upd)  r_pend <= r_pend & w_tick;
      else if (w_tick)  r_pend <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_start_clr) begin
            r_state <= ST_CLEAR;
            r_last  <= neuron_last;
            r_addr  <= '0;
          end else if (w_start_upd) begin
            r_state <= ST_UPDATE;
            r_last  <= neuron_last;
            r_addr  <= '0;
          end
        end
        ST_UPDATE, ST_CLEAR: begin
          if (w_issue) begin
            if (r_addr == r_last) begin
              r_state <= ST_DRAIN;
              r_addr  <= '0;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sched_busy          = (r_state != ST_IDLE);
  assign sched_done          = (r_state == ST_DRAIN);
  assign sched_overrun       = r_ovr;
  assign config_soma_vld     = w_issue;
  assign config_soma_vm_addr = r_addr;
  assign config_soma_clear   = w_issue & (r_state == ST_CLEAR);
  assign axon_gnt            = w_gnt;

  spk_fifo #(.W(NNW), .AW(SFAW)) u_spk_fifo (
    .clk     (clk_soma),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (r_addr_q),
    .i_pop   (spk_ready),
    .o_valid (spk_valid),
    .o_dout  (spk_addr),
    .o_count (w_fcnt)
  );

`ifdef SOMA_SCHED_PERF_EN
  logic [PCW-1:0] r_stall;

  always_ff @(posedge clk_soma) begin
    if (!rst_n)                            r_stall <= '0;
    else if (w_start_upd | w_start_clr)    r_stall <= '0;
    else if (w_active & !w_issue & (r_stall != '1)) r_stall <= r_stall + 1'b1;
  end

  assign perf_stall_cnt = r_stall;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule
